// File: rtl/mac_seq_unit.sv
// mac_seq_unit: sequential multiply-accumulate for the switch/LED lab boards.
// Operands come from the switch bus, the "go" button is debounced, and the
// product is formed by a DATA_W-cycle shift-add loop before being added into
// a saturating or wrapping accumulator. All outputs are registered.
module mac_seq_unit #(
   parameter int DATA_W          = 8,
   parameter int ACC_W           = 16,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter bit SATURATE        = 1'b1
) (
   input  logic              clk,
   input  logic              btnC_n,
   input  logic [DATA_W-1:0] din,
   input  logic              load_a,
   input  logic              load_b,
   input  logic              go,
   input  logic              clear,
   output logic [ACC_W-1:0]  acc,
   output logic              ovf,
   output logic              busy,
   output logic              done
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int ITER_W = $clog2(DATA_W + 1);
   localparam int EXT_W  = ACC_W + 1 - PROD_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_ACC  = 2'd2
   } state_t;

   // Operand registers loaded from the switches while idle
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;

   // Debounce state
   logic [CNT_W-1:0]  db_cnt_reg;
   logic              go_db_prev_reg;
   logic              go_db;
   logic              start_evt;

   // Shift-add datapath
   state_t            state_reg;
   logic [PROD_W-1:0] mcand_reg;
   logic [DATA_W-1:0] mplier_reg;
   logic [PROD_W-1:0] prod_reg;
   logic [ITER_W-1:0] iter_reg;
   logic [PROD_W-1:0] addend;

   // Accumulator path
   logic [ACC_W:0]    sum;
   logic              sum_carry;
   logic [ACC_W-1:0]  acc_next;

   // Registered outputs
   logic [ACC_W-1:0]  acc_reg;
   logic              ovf_reg;
   logic              busy_reg;
   logic              done_reg;

   // The raw button is fed straight into the counter: any bounce low clears
   // it, so a glitchy press simply restarts the qualification window.
   assign go_db     = (db_cnt_reg == CNT_W'(DEBOUNCE_CYCLES));
   assign start_evt = go_db & ~go_db_prev_reg;

   // Debounce counter: count consecutive high samples, saturate, clear on low
   always_ff @(posedge clk or negedge btnC_n) begin
      if (!btnC_n) begin
         db_cnt_reg     <= '0;
         go_db_prev_reg <= 1'b0;
      end else begin
         go_db_prev_reg <= go_db;
         if (!go) begin
            db_cnt_reg <= '0;
         end else if (!go_db) begin
            db_cnt_reg <= db_cnt_reg + CNT_W'(1);
         end
      end
   end

   // Operand capture; frozen while an operation is running
   always_ff @(posedge clk or negedge btnC_n) begin
      if (!btnC_n) begin
         a_reg <= '0;
         b_reg <= '0;
      end else if (!busy_reg) begin
         if (load_a) begin
            a_reg <= din;
         end
         if (load_b) begin
            b_reg <= din;
         end
      end
   end

   // Partial product for this iteration: the shifted multiplicand gated by
   // the current multiplier LSB.
   generate
      for (genvar gi = 0; gi < PROD_W; gi++) begin : g_addend
         assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
      end
   endgenerate

   // Widen by one bit so the carry out of the accumulator is visible
   assign sum       = {1'b0, acc_reg} + {{EXT_W{1'b0}}, prod_reg};
   assign sum_carry = sum[ACC_W];

   // Overflow policy chosen at elaboration time
   generate
      if (SATURATE) begin : g_sat
         assign acc_next = sum_carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
      end else begin : g_wrap
         assign acc_next = sum[ACC_W-1:0];
      end
   endgenerate

   // Control FSM with the shift-add datapath and all registered outputs
   always_ff @(posedge clk or negedge btnC_n) begin
      if (!btnC_n) begin
         state_reg  <= ST_IDLE;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         prod_reg   <= '0;
         iter_reg   <= '0;
         acc_reg    <= '0;
         ovf_reg    <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start_evt) begin
                  mcand_reg  <= {{DATA_W{1'b0}}, a_reg};
                  mplier_reg <= b_reg;
                  prod_reg   <= '0;
                  iter_reg   <= '0;
                  busy_reg   <= 1'b1;
                  state_reg  <= ST_MUL;
               end
            end
            ST_MUL: begin
               prod_reg   <= prod_reg + addend;
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               iter_reg   <= iter_reg + ITER_W'(1);
               if (iter_reg == ITER_W'(DATA_W - 1)) begin
                  state_reg <= ST_ACC;
               end
            end
            ST_ACC: begin
               acc_reg  <= acc_next;
               if (sum_carry) begin
                  ovf_reg <= 1'b1;
               end
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
         // Clear wins over any accumulate in the same cycle; an operation in
         // flight keeps running and later adds into the cleared value.
         if (clear) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
         end
      end
   end

   assign acc  = acc_reg;
   assign ovf  = ovf_reg;
   assign busy = busy_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_mac_seq_unit.sv
// Bench for mac_seq_unit: a saturating and a wrapping instance share stimulus.
// A cycle-level behavioural model (plain arithmetic) is compared every cycle,
// and directed scenarios add hand-computed literal expectations.
module tb_mac_seq_unit;

   localparam int  DW      = 8;
   localparam int  AW      = 16;
   localparam int  DB      = 16;
   localparam longint ACC_MAX = 65535;

   logic          clk = 1'b0;
   logic          btnC_n = 1'b0;
   logic [DW-1:0] din = '0;
   logic          load_a = 1'b0;
   logic          load_b = 1'b0;
   logic          go = 1'b0;
   logic          clear = 1'b0;

   logic [AW-1:0] acc_s, acc_w;
   logic          ovf_s, ovf_w, busy_s, busy_w, done_s, done_w;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int go_cyc = 0;
   int done_cyc = 0;
   int done_count = 0;

   // model state
   longint m_a, m_b, m_prod, m_acc_s, m_acc_w;
   int     m_cnt, m_phase;
   bit     m_prev, m_ovf_s, m_ovf_w, m_done;

   always #5 clk = ~clk;

   mac_seq_unit #(.DATA_W(DW), .ACC_W(AW), .DEBOUNCE_CYCLES(DB), .SATURATE(1'b1)) dut_s (
      .clk(clk), .btnC_n(btnC_n), .din(din), .load_a(load_a), .load_b(load_b),
      .go(go), .clear(clear), .acc(acc_s), .ovf(ovf_s), .busy(busy_s), .done(done_s)
   );

   mac_seq_unit #(.DATA_W(DW), .ACC_W(AW), .DEBOUNCE_CYCLES(DB), .SATURATE(1'b0)) dut_w (
      .clk(clk), .btnC_n(btnC_n), .din(din), .load_a(load_a), .load_b(load_b),
      .go(go), .clear(clear), .acc(acc_w), .ovf(ovf_w), .busy(busy_w), .done(done_w)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model step at each rising edge, then compare DUT outputs 1 time unit later
   initial begin
      bit     was_busy, db, start;
      longint sum;
      forever begin
         @(posedge clk);
         cyc++;
         if (btnC_n !== 1'b1) begin
            m_a = 0; m_b = 0; m_prod = 0; m_acc_s = 0; m_acc_w = 0;
            m_cnt = 0; m_phase = 0; m_prev = 0; m_ovf_s = 0; m_ovf_w = 0; m_done = 0;
         end else begin
            was_busy = (m_phase != 0);
            db       = (m_cnt == DB);
            start    = db && !m_prev;
            m_prev   = db;
            m_cnt    = go ? ((m_cnt < DB) ? m_cnt + 1 : DB) : 0;
            m_done   = 0;
            if (was_busy) begin
               m_phase--;
               if (m_phase == 0) begin
                  m_done = 1;
                  sum = m_acc_s + m_prod;
                  if (sum > ACC_MAX) begin m_acc_s = ACC_MAX; m_ovf_s = 1; end
                  else m_acc_s = sum;
                  sum = m_acc_w + m_prod;
                  if (sum > ACC_MAX) begin m_acc_w = sum - (ACC_MAX + 1); m_ovf_w = 1; end
                  else m_acc_w = sum;
               end
            end else if (start) begin
               m_phase = DW + 1;
               m_prod  = m_a * m_b;
            end
            if (!was_busy) begin
               if (load_a) m_a = din;
               if (load_b) m_b = din;
            end
            if (clear) begin
               m_acc_s = 0; m_acc_w = 0; m_ovf_s = 0; m_ovf_w = 0;
            end
         end
         #1;
         check("busy_s", busy_s, (m_phase != 0));
         check("busy_w", busy_w, (m_phase != 0));
         check("done_s", done_s, m_done);
         check("done_w", done_w, m_done);
         check("acc_s", acc_s, m_acc_s);
         check("acc_w", acc_w, m_acc_w);
         check("ovf_s", ovf_s, m_ovf_s);
         check("ovf_w", ovf_w, m_ovf_w);
         if (done_s === 1'b1) begin
            done_count++;
            done_cyc = cyc;
         end
      end
   end

   // Hard stop if the run ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input int a, input int b);
      din = DW'(a); load_a = 1'b1; tick(1);
      load_a = 1'b0; din = DW'(b); load_b = 1'b1; tick(1);
      load_b = 1'b0;
   endtask

   task automatic press(input int hold);
      go = 1'b1;
      go_cyc = cyc + 1;
      tick(hold);
      go = 1'b0;
      tick(12);
   endtask

   task automatic op(input int a, input int b);
      load(a, b);
      press(20);
      $display("op a=%0d b=%0d acc_s=%0d ovf_s=%0d acc_w=%0d ovf_w=%0d",
               a, b, acc_s, ovf_s, acc_w, ovf_w);
   endtask

   initial begin
      int d0;
      tick(3);
      btnC_n = 1'b1;
      tick(1);
      check("reset_acc", acc_s, 0);
      check("reset_busy", busy_s, 0);
      check("reset_done", done_s, 0);

      // Basic MAC and latency
      done_cyc = 0;
      op(3, 4);
      check("op1_acc_s", acc_s, 12);
      check("op1_acc_w", acc_w, 12);
      check("op1_latency", done_cyc - go_cyc, 25);
      op(2, 5);
      check("op2_acc", acc_s, 22);
      d0 = done_count;
      op(0, 7);
      check("zero_op_acc", acc_s, 22);
      check("zero_op_done", done_count - d0, 1);

      // Bounce: one accepted press; short press ignored
      d0 = done_count;
      go = 1'b1; tick(10); go = 1'b0; tick(1);
      press(20);
      check("bounce_one_done", done_count - d0, 1);
      d0 = done_count;
      press(15);
      tick(5);
      check("short_press_done", done_count - d0, 0);
      $display("bounce presses done_count=%0d", done_count);

      // Saturate vs wrap
      clear = 1'b1; tick(1); clear = 1'b0; tick(1);
      check("clear_acc", acc_s, 0);
      op(255, 255);
      check("sq1_acc_s", acc_s, 65025);
      check("sq1_ovf_s", ovf_s, 0);
      op(255, 255);
      check("sq2_acc_s", acc_s, 65535);
      check("sq2_ovf_s", ovf_s, 1);
      check("sq2_acc_w", acc_w, 64514);
      check("sq2_ovf_w", ovf_w, 1);
      op(1, 1);
      check("sat_hold_acc", acc_s, 65535);
      clear = 1'b1; tick(1); clear = 1'b0; tick(1);
      check("clear2_acc", acc_s, 0);
      check("clear2_ovf", ovf_s, 0);
      check("clear2_ovf_w", ovf_w, 0);

      // Busy interlocks: loads and go pulses during MUL are ignored
      load(3, 4);
      d0 = done_count;
      go = 1'b1; tick(18);
      din = 8'd9; load_a = 1'b1; go = 1'b0; tick(1);
      go = 1'b1; tick(1); go = 1'b0; tick(2);
      load_a = 1'b0; tick(12);
      check("interlock_acc", acc_s, 12);
      check("interlock_done", done_count - d0, 1);
      press(20);
      check("a_kept_acc", acc_s, 24);
      $display("interlock acc_s=%0d", acc_s);

      // Asynchronous reset mid-operation
      load(3, 4);
      d0 = done_count;
      go = 1'b1; tick(18);
      btnC_n = 1'b0; go = 1'b0;
      #1;
      check("async_rst_busy", busy_s, 0);
      check("async_rst_acc", acc_s, 0);
      tick(2);
      btnC_n = 1'b1;
      tick(15);
      check("rst_no_done", done_count - d0, 0);

      // Clear during MUL does not abort; clear at ACC discards but pulses done
      op(3, 4);
      check("post_rst_acc", acc_s, 12);
      go = 1'b1; tick(20); clear = 1'b1; tick(1); clear = 1'b0;
      go = 1'b0; tick(12);
      check("clear_mul_acc", acc_s, 12);
      d0 = done_count;
      go = 1'b1; tick(20); go = 1'b0; tick(5);
      clear = 1'b1; tick(1); clear = 1'b0; tick(6);
      check("clear_acc_cycle_acc", acc_s, 0);
      check("clear_acc_cycle_done", done_count - d0, 1);
      $display("clear tests acc_s=%0d acc_w=%0d", acc_s, acc_w);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac_seq_unit.md
# mac_seq_unit

Parametrised sequential multiply-accumulate unit for the switch/LED lab designs. It captures two operands from the switch bus, debounces the "go" input, and multiplies with a DATA_W-cycle shift-add datapath. It then adds the product into a saturating or wrapping accumulator. It sits between the board I/O (switches, buttons) and the LED/seven-segment display blocks, replacing the fixed 8-bit single-cycle MAC.

## Interface
Parameters:
- DATA_W, 8, operand width (unsigned).
- ACC_W, 16, accumulator width; must satisfy ACC_W >= 2*DATA_W.
- DEBOUNCE_CYCLES, 16, consecutive high cycles required to accept `go`.
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- btnC_n  in  1  asynchronous, active-low reset.
- din  in  DATA_W  operand data from switches.
- load_a  in  1  level; while high and not busy, A <= din each cycle.
- load_b  in  1  level; while high and not busy, B <= din each cycle.
- go  in  1  raw (bouncy) start request.
- clear  in  1  synchronous clear of accumulator and overflow flag.
- acc  out  ACC_W  accumulator value (drives LEDs/display).
- ovf  out  1  sticky overflow flag.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when acc takes a new value.

## Operation
- Reset (btnC_n low, asynchronous): A=B=0, acc=0, ovf=0, busy=0, done=0, debounce counter=0, FSM=IDLE. Reset mid-operation aborts it. No partial result is written.
- Debounce:
  - Counter increments while `go`=1 and saturates at DEBOUNCE_CYCLES. It clears to 0 on any cycle with `go`=0.
  - Debounced level `go_db` = (counter == DEBOUNCE_CYCLES).
  - Start event = rising edge of `go_db`. Exactly one operation per accepted press; holding `go` does not retrigger.
- FSM states:
  - IDLE: busy=0. On a start event, latch A into the multiplicand and B into the multiplier, clear the product register, and go to MUL.
  - MUL: DATA_W iterations. Each cycle, if multiplier LSB=1, add the shifted multiplicand into the 2*DATA_W-bit product. Then shift multiplicand left and multiplier right. After the DATA_W-th iteration, go to ACC.
  - ACC: sum = acc + zero-extended product, computed in ACC_W+1 bits.
    - If the sum has no carry: acc <= sum.
    - If the sum carries: ovf <= 1, and acc <= all ones when SATURATE=1, else sum[ACC_W-1:0].
    - done=1 this cycle. Return to IDLE.
- Start events arriving while busy are ignored.
- load_a/load_b are ignored while busy, so the operation uses the values latched at start.
- `clear` priority over accumulate: clear in any cycle sets acc=0 and ovf=0. If clear coincides with ACC, the product is discarded, acc=0 and done still pulses. Clear during MUL does not abort; the product later adds to 0.
- load_a and load_b high in the same cycle both take din.
- A=0 or B=0 gives product 0; acc is unchanged and done still pulses.

## Timing
- Start event on edge N: busy=1 from edge N+1.
- MUL occupies edges N+1..N+DATA_W.
- ACC at edge N+DATA_W+1: acc/ovf update and done=1 for that cycle only. busy=0 from edge N+DATA_W+2.
- Press-to-result latency: DEBOUNCE_CYCLES + DATA_W + 1 cycles after `go` first samples high, assuming no bounce.
- A new start event is accepted the cycle busy returns to 0.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
1. Default params. Reset; load A=3, B=4; hold go 20 cycles -> done pulse, acc=12, ovf=0. Then A=2, B=5, go -> acc=22.
2. Bounce: go high 10 cycles, low 1, high 20 -> exactly one done pulse. Go high 15 cycles then low -> no operation.
3. Saturation (SATURATE=1): A=B=255, go twice -> acc 65025 then 65535 with ovf=1. A further 1*1 keeps 65535. Clear -> acc=0, ovf=0.
4. Wrap (SATURATE=0): A=B=255 twice -> acc=64514, ovf=1.
5. Busy interlocks: during MUL of 3*4, drive load_a with din=9 and pulse go -> result 12. After the operation A=3, and no second done pulse.
6. Reset/clear mid-op: btnC_n low during MUL -> acc=0, busy=0, no done pulse. Clear asserted in the ACC cycle -> acc=0 with done pulse.
